k12a_sequencer: RTL and testbench

K12A_SEQUENCER -- requirements
Module: k12a_sequencer

---
 rtl/k12a_pkg.sv | 26 ++
 rtl/k12a_sync2.sv | 21 ++
 rtl/k12a_sequencer.sv | 114 +++++++++++
 tb/tb_k12a_sequencer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/k12a_pkg.sv
// Shared K12A CPU types: control-FSM state encoding and skip-flag update selects.
package k12a_pkg;

    typedef enum logic [2:0] {
        STATE_FETCH1 = 3'd0,
        STATE_FETCH2 = 3'd1,
        STATE_FETCH3 = 3'd2,
        STATE_EXEC   = 3'd3,
        STATE_POP    = 3'd4,
        STATE_RJMP   = 3'd5,
        STATE_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        SKIP_SEL_HOLD        = 2'd0,
        SKIP_SEL_0           = 2'd1,
        SKIP_SEL_CONDITION   = 2'd2,
        SKIP_SEL_CONDITION_N = 2'd3
    } skip_sel_t;

    // States that finish an instruction and normally return to FETCH1.
    function automatic logic is_step_boundary(input state_t s);
        return (s == STATE_EXEC) || (s == STATE_POP) || (s == STATE_RJMP);
    endfunction

endpackage

// File: rtl/k12a_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; clears on reset.
module k12a_sync2 (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/k12a_sequencer.sv
// K12A datapath sequencer: state register, instruction latch, skip flag, wake sync, retire counter.
// Optional single-step halting is enabled with `define K12A_SINGLE_STEP_EN.
//
// state        | meaning
// FETCH1..3    | instruction fetch phases
// EXEC         | instruction executes (counted as retired)
// POP / RJMP   | extra cycle for stack pop / relative jump
// HALT         | stopped until the control FSM (or a step wake) resumes
module k12a_sequencer
    import k12a_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  state_t      state_next,
    output state_t      state,
    output logic        halted,
    input  logic [7:0]  data_bus,
    input  logic        inst_high_store,
    input  logic        inst_low_store,
    output logic [15:0] inst,
    input  skip_sel_t   skip_sel,
    input  logic        alu_condition,
    output logic        skip,
    input  logic        wake_async,
    output logic        wake,
    output logic [15:0] retired_count
`ifdef K12A_SINGLE_STEP_EN
    ,
    input  logic        step_mode
`endif
);

    state_t state_d;
    logic   wake_sync;
    logic   wake_prev;

    k12a_sync2 u_wake_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (wake_async),
        .q       (wake_sync)
    );

    assign wake   = wake_sync & ~wake_prev;
    assign halted = (state == STATE_HALT);

`ifdef K12A_SINGLE_STEP_EN
    logic step_hold;
    logic step_hold_d;

    // A step halt is released only by a wake pulse, independent of state_next.
    always_comb begin
        state_d     = state_next;
        step_hold_d = step_hold;
        if (step_hold && (state == STATE_HALT)) begin
            state_d = wake ? STATE_FETCH1 : STATE_HALT;
            if (wake) begin
                step_hold_d = 1'b0;
            end
        end else if (step_mode && (state_next == STATE_FETCH1) && is_step_boundary(state)) begin
            state_d     = STATE_HALT;
            step_hold_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            step_hold <= 1'b0;
        end else begin
            step_hold <= step_hold_d;
        end
    end
`else
    always_comb begin
        state_d = state_next;
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= STATE_FETCH1;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inst          <= 16'h0000;
            skip          <= 1'b0;
            wake_prev     <= 1'b0;
            retired_count <= 16'h0000;
        end else begin
            if (inst_high_store) begin
                inst[15:8] <= data_bus;
            end
            if (inst_low_store) begin
                inst[7:0] <= data_bus;
            end
            case (skip_sel)
                SKIP_SEL_HOLD:        skip <= skip;
                SKIP_SEL_0:           skip <= 1'b0;
                SKIP_SEL_CONDITION:   skip <= alu_condition;
                SKIP_SEL_CONDITION_N: skip <= ~alu_condition;
                default:              skip <= skip;
            endcase
            wake_prev <= wake_sync;
            if (state == STATE_EXEC) begin
                retired_count <= retired_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_k12a_sequencer.sv
// Self-checking bench for k12a_sequencer (default build): directed scenarios plus randomized traffic.
module tb_k12a_sequencer;
    import k12a_pkg::*;

    logic        clock;
    logic        reset_n;
    state_t      state_next;
    state_t      state;
    logic        halted;
    logic [7:0]  data_bus;
    logic        inst_high_store;
    logic        inst_low_store;
    logic [15:0] inst;
    skip_sel_t   skip_sel;
    logic        alu_condition;
    logic        skip;
    logic        wake_async;
    logic        wake;
    logic [15:0] retired_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    state_t      m_state;
    logic [15:0] m_inst;
    logic        m_skip;
    logic [15:0] m_count;
    bit          m_samples[$];

    k12a_sequencer dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .state_next      (state_next),
        .state           (state),
        .halted          (halted),
        .data_bus        (data_bus),
        .inst_high_store (inst_high_store),
        .inst_low_store  (inst_low_store),
        .inst            (inst),
        .skip_sel        (skip_sel),
        .alu_condition   (alu_condition),
        .skip            (skip),
        .wake_async      (wake_async),
        .wake            (wake),
        .retired_count   (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state = STATE_FETCH1;
        m_inst  = 16'h0000;
        m_skip  = 1'b0;
        m_count = 16'h0000;
        m_samples.delete();
        repeat (3) m_samples.push_back(1'b0);
    endfunction

    // Wake is expected after an edge iff the input was sampled high one edge earlier and low the edge before that.
    function automatic bit model_wake();
        int n;
        n = m_samples.size();
        return m_samples[n-2] && !m_samples[n-3];
    endfunction

    function automatic void model_edge();
        if (!reset_n) begin
            model_reset();
            return;
        end
        if (m_state == STATE_EXEC) m_count = m_count + 16'd1;
        m_state = state_next;
        if (inst_high_store) m_inst[15:8] = data_bus;
        if (inst_low_store)  m_inst[7:0]  = data_bus;
        case (skip_sel)
            SKIP_SEL_0:           m_skip = 1'b0;
            SKIP_SEL_CONDITION:   m_skip = alu_condition;
            SKIP_SEL_CONDITION_N: m_skip = !alu_condition;
            default:              m_skip = m_skip;
        endcase
        m_samples.push_back(wake_async);
        if (m_samples.size() > 6) void'(m_samples.pop_front());
    endfunction

    task automatic compare_all();
        check_eq("state",    state,         m_state);
        check_eq("halted",   halted,        (m_state == STATE_HALT));
        check_eq("inst",     inst,          m_inst);
        check_eq("skip",     skip,          m_skip);
        check_eq("wake",     wake,          model_wake());
        check_eq("retired",  retired_count, m_count);
    endtask

    // One clock: model follows the edge, outputs checked 1ns later; caller drives new inputs afterwards.
    task automatic step_clk();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_eq("rst_state",   state,         STATE_FETCH1);
        check_eq("rst_inst",    inst,          16'h0000);
        check_eq("rst_skip",    skip,          1'b0);
        check_eq("rst_wake",    wake,          1'b0);
        check_eq("rst_retired", retired_count, 16'h0000);
        step_clk();
        step_clk();
        reset_n = 1'b1;
    endtask

    task automatic idle_inputs();
        state_next      = STATE_FETCH1;
        data_bus        = 8'h00;
        inst_high_store = 1'b0;
        inst_low_store  = 1'b0;
        skip_sel        = SKIP_SEL_HOLD;
        alu_condition   = 1'b0;
    endtask

    initial begin
        int pulses;
        int first_pulse;
        state_t seq[4];

        reset_n    = 1'b0;
        wake_async = 1'b0;
        idle_inputs();
        model_reset();

        // Reset / fetch sequence
        #2;
        do_reset();
        seq[0] = STATE_FETCH2; seq[1] = STATE_FETCH3; seq[2] = STATE_EXEC; seq[3] = STATE_FETCH1;
        for (int i = 0; i < 4; i++) begin
            state_next = seq[i];
            step_clk();
            check_eq("fetch_seq", state, seq[i]);
        end
        check_eq("fetch_retired", retired_count, 16'd1);

        // Instruction load
        data_bus = 8'hA5; inst_high_store = 1'b1;
        step_clk();
        data_bus = 8'h3C; inst_high_store = 1'b0; inst_low_store = 1'b1;
        step_clk();
        check_eq("inst_a53c", inst, 16'hA53C);
        data_bus = 8'h7E; inst_high_store = 1'b1; inst_low_store = 1'b1;
        step_clk();
        check_eq("inst_7e7e", inst, 16'h7E7E);
        inst_high_store = 1'b0; inst_low_store = 1'b0; data_bus = 8'hFF;
        step_clk();
        check_eq("inst_hold", inst, 16'h7E7E);

        // Skip flag
        skip_sel = SKIP_SEL_CONDITION; alu_condition = 1'b1;
        step_clk();
        check_eq("skip_cond", skip, 1'b1);
        skip_sel = SKIP_SEL_HOLD; alu_condition = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_clk();
            check_eq("skip_hold", skip, 1'b1);
        end
        skip_sel = SKIP_SEL_CONDITION_N; alu_condition = 1'b1;
        step_clk();
        check_eq("skip_condn1", skip, 1'b0);
        alu_condition = 1'b0;
        step_clk();
        check_eq("skip_condn0", skip, 1'b1);
        skip_sel = SKIP_SEL_0;
        step_clk();
        check_eq("skip_clear", skip, 1'b0);
        skip_sel = SKIP_SEL_HOLD;

        // Halt / wake: one pulse, two edges after the rise, level held for 10 cycles
        state_next = STATE_HALT;
        step_clk();
        check_eq("halt_entered", halted, 1'b1);
        wake_async  = 1'b1;
        pulses      = 0;
        first_pulse = -1;
        for (int i = 1; i <= 10; i++) begin
            step_clk();
            check_eq("halt_held", halted, 1'b1);
            if (wake) begin
                pulses++;
                if (first_pulse < 0) first_pulse = i;
            end
        end
        check_eq("wake_pulses", pulses, 1);
        check_eq("wake_latency", first_pulse, 2);
        check_eq("halt_inst_kept", inst, 16'h7E7E);
        wake_async = 1'b0;
        state_next = STATE_FETCH1;
        step_clk();
        step_clk();

        // Counter wrap
        do_reset();
        state_next = STATE_EXEC;
        step_clk();
        for (int i = 0; i < 65535; i++) step_clk();
        check_eq("wrap_ffff", retired_count, 16'hFFFF);
        step_clk();
        check_eq("wrap_0000", retired_count, 16'h0000);
        idle_inputs();
        step_clk();

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 4000; i++) begin
            state_next      = state_t'(3'($urandom_range(0, 6)));
            data_bus        = 8'($urandom);
            inst_high_store = 1'($urandom);
            inst_low_store  = 1'($urandom);
            skip_sel        = skip_sel_t'(2'($urandom_range(0, 3)));
            alu_condition   = 1'($urandom);
            if ($urandom_range(0, 5) == 0) wake_async = ~wake_async;
            if ($urandom_range(0, 299) == 0) begin
                #2;
                do_reset();
            end else begin
                step_clk();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
